// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use and
// MDU-occupancy stalls, taken-branch flushes, imem wait states, perf counters.
module hazard_ctrl #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_mdu,
  input  logic             id_reads_hilo,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    RUN,
    MDU_BUSY
  } mduState_e;

  localparam logic [3:0] MduLoad = 4'(MDU_LATENCY);

  mduState_e        mduStateQ, mduStateD;
  logic [3:0]       mduCntQ, mduCntD;
  logic [CNT_W-1:0] stallCntQ, stallCntD;
  logic [CNT_W-1:0] flushCntQ, flushCntD;

  logic loadUse;
  logic mduHz;
  logic idStall;
  logic issue;

  // $zero is never a real load destination, so it cannot create a dependency.
  assign loadUse = ex_memread && (ex_rt != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_rt)) ||
                    (id_uses_rt && (id_rt == ex_rt)));
  assign mduHz   = (mduCntQ != 4'd0) && (id_is_mdu || id_reads_hilo);
  assign idStall = loadUse || mduHz;
  assign issue   = id_is_mdu && !idStall && !ex_branch_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mduStateQ <= RUN;
      mduCntQ   <= 4'd0;
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      mduStateQ <= mduStateD;
      mduCntQ   <= mduCntD;
      stallCntQ <= stallCntD;
      flushCntQ <= flushCntD;
    end
  end

  // A taken branch never cancels an op in flight; only issue reloads the count.
  always_comb begin
    mduStateD = mduStateQ;
    mduCntD   = mduCntQ;
    case (mduStateQ)
      RUN: begin
        if (issue) begin
          mduCntD   = MduLoad;
          mduStateD = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        if (issue) begin
          mduCntD = MduLoad;
        end else if (mduCntQ != 4'd0) begin
          mduCntD = mduCntQ - 4'd1;
          if (mduCntQ == 4'd1) begin
            mduStateD = RUN;
          end
        end else begin
          mduStateD = RUN;
        end
      end
      default: begin
        mduStateD = RUN;
        mduCntD   = 4'd0;
      end
    endcase
  end

  always_comb begin
    stallCntD = stallCntQ;
    flushCntD = flushCntQ;
    if (idStall && !ex_branch_taken && (stallCntQ != '1)) begin
      stallCntD = stallCntQ + 1'b1;
    end
    if (ex_branch_taken && (flushCntQ != '1)) begin
      flushCntD = flushCntQ + 1'b1;
    end
  end

  // Priority: reset, wrong-path flush, ID stall, imem wait, free run.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (idStall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  assign mdu_busy     = (mduCntQ != 4'd0);
  assign stall_cycles = stallCntQ;
  assign flush_count  = flushCntQ;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with CNT_W=4 and MDU_LATENCY=4.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, id_is_mdu, id_reads_hilo;
  logic       ex_memread, ex_branch_taken, imem_ready;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy;
  logic [3:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_mdu(id_is_mdu), .id_reads_hilo(id_reads_hilo),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .mdu_busy(mdu_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkCnt(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkCtrl(input string tag, input logic pc, input logic ie,
                           input logic iflush, input logic xflush);
    checkBit({tag, ".pc_en"}, pc_en, pc);
    checkBit({tag, ".ifid_en"}, ifid_en, ie);
    checkBit({tag, ".ifid_flush"}, ifid_flush, iflush);
    checkBit({tag, ".idex_flush"}, idex_flush, xflush);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_mdu = 1'b0; id_reads_hilo = 1'b0;
    ex_memread = 1'b0; ex_branch_taken = 1'b0; imem_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();
    #2;
    checkCtrl("reset", 1'b0, 1'b0, 1'b1, 1'b1);
    checkBit("reset.mdu_busy", mdu_busy, 1'b0);
    checkCnt("reset.stall_cycles", stall_cycles, 4'd0);
    checkCnt("reset.flush_count", flush_count, 4'd0);
    nextCycle();
    reset = 1'b0;
    #1;
    checkCtrl("run", 1'b1, 1'b1, 1'b0, 1'b0);

    // load-use on rs
    ex_memread = 1'b1; ex_rt = 5'd8; id_uses_rs = 1'b1; id_rs = 5'd8;
    #1;
    checkCtrl("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkCnt("lu_rs.stall_cycles", stall_cycles, 4'd1);
    ex_memread = 1'b0;
    #1;
    checkCtrl("lu_done", 1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    checkCnt("lu_done.stall_cycles", stall_cycles, 4'd1);

    // $zero destination never stalls
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    checkCtrl("lu_zero", 1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    checkCnt("lu_zero.stall_cycles", stall_cycles, 4'd1);

    // load-use on rt, then rt match that is not read
    id_uses_rs = 1'b0; id_rs = 5'd3; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    #1;
    checkCtrl("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkCnt("lu_rt.stall_cycles", stall_cycles, 4'd2);
    id_uses_rt = 1'b0;
    #1;
    checkCtrl("lu_rt_unused", 1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();

    // branch during load-use stall
    id_uses_rt = 1'b1; ex_branch_taken = 1'b1;
    #1;
    checkCtrl("br_stall", 1'b1, 1'b1, 1'b1, 1'b1);
    nextCycle();
    checkCnt("br_stall.stall_cycles", stall_cycles, 4'd2);
    checkCnt("br_stall.flush_count", flush_count, 4'd1);

    // branch overrides imem wait
    clearInputs();
    ex_branch_taken = 1'b1; imem_ready = 1'b0;
    #1;
    checkCtrl("br_imem", 1'b1, 1'b1, 1'b1, 1'b1);
    nextCycle();
    checkCnt("br_imem.flush_count", flush_count, 4'd2);

    // mult then mfhi: four stalled cycles, advance on the fifth
    clearInputs();
    id_is_mdu = 1'b1;
    #1;
    checkCtrl("mult_issue", 1'b1, 1'b1, 1'b0, 1'b0);
    checkBit("mult_issue.mdu_busy", mdu_busy, 1'b0);
    nextCycle();
    id_is_mdu = 1'b0; id_reads_hilo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkBit($sformatf("mfhi_wait%0d.mdu_busy", i), mdu_busy, 1'b1);
      checkCtrl($sformatf("mfhi_wait%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      nextCycle();
    end
    #1;
    checkBit("mfhi_go.mdu_busy", mdu_busy, 1'b0);
    checkCtrl("mfhi_go", 1'b1, 1'b1, 1'b0, 1'b0);
    checkCnt("mfhi_go.stall_cycles", stall_cycles, 4'd6);
    nextCycle();

    // imem wait for three cycles
    clearInputs();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkCtrl($sformatf("imem_wait%0d", i), 1'b0, 1'b1, 1'b1, 1'b0);
      nextCycle();
    end
    imem_ready = 1'b1;
    #1;
    checkCtrl("imem_resume", 1'b1, 1'b1, 1'b0, 1'b0);
    checkCnt("imem_resume.stall_cycles", stall_cycles, 4'd6);

    // branch does not cancel an MDU op in flight
    id_is_mdu = 1'b1;
    nextCycle();
    id_is_mdu = 1'b0; ex_branch_taken = 1'b1;
    nextCycle();
    ex_branch_taken = 1'b0;
    #1;
    checkBit("br_mdu.mdu_busy", mdu_busy, 1'b1);
    nextCycle();
    checkBit("mid_mdu.mdu_busy", mdu_busy, 1'b1);

    // asynchronous reset with two cycles left on the MDU
    reset = 1'b1;
    #1;
    checkBit("async_rst.mdu_busy", mdu_busy, 1'b0);
    checkCnt("async_rst.stall_cycles", stall_cycles, 4'd0);
    checkCnt("async_rst.flush_count", flush_count, 4'd0);
    checkCtrl("async_rst", 1'b0, 1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    id_reads_hilo = 1'b1;
    #1;
    checkCtrl("post_rst_mfhi", 1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    checkCnt("post_rst_mfhi.stall_cycles", stall_cycles, 4'd0);

    // hold a load-use stall for 21 cycles: counter saturates at 15
    clearInputs();
    ex_memread = 1'b1; ex_rt = 5'd5; id_uses_rs = 1'b1; id_rs = 5'd5;
    for (int i = 0; i < 15; i++) nextCycle();
    checkCnt("sat15.stall_cycles", stall_cycles, 4'd15);
    for (int i = 0; i < 6; i++) nextCycle();
    checkCnt("sat21.stall_cycles", stall_cycles, 4'd15);
    checkCtrl("sat21", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage MIPS core. It drives the PC enable and the IF/ID load-enable and flush controls, plus the ID/EX bubble insertion. It resolves load-use hazards, taken-branch redirects, instruction-memory wait states and multi-cycle MDU (mult/div) occupancy. It also keeps saturating stall and flush performance counters.

Parameters:
MDU_LATENCY, 4, cycles the MDU is busy after a mult/div leaves ID (legal range 1..15)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_is_mdu  in  1  ID instruction is mult/multu/div/divu
id_reads_hilo  in  1  ID instruction is mfhi/mflo
ex_memread  in  1  EX instruction is a load
ex_rt  in  5  destination register of the EX load
ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
imem_ready  in  1  instruction memory returns valid data for the current PC
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads a nop (0x00000000) at the next edge; dominates ifid_en
idex_flush  out  1  ID/EX loads a bubble at the next edge
mdu_busy  out  1  MDU countdown is non-zero
stall_cycles  out  CNT_W  count of ID-stall cycles
flush_count  out  CNT_W  count of taken-branch flushes

Behaviour:
- Reset (async): mdu_cnt=0, state=RUN, both counters=0. While reset is high, pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, mdu_busy=0.
- load_use = ex_memread & (ex_rt!=0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- mdu_hz = (mdu_cnt!=0) & (id_is_mdu | id_reads_hilo).
- id_stall = load_use | mdu_hz.
- Control outputs are combinational from inputs and state, in fixed priority:
  1. ex_branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. Overrides id_stall and imem_ready=0, because the ID instruction is wrong-path.
  2. id_stall: pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1. IF/ID holds its value, and a bubble enters EX.
  3. !imem_ready: pc_en=0, ifid_en=1, ifid_flush=1, idex_flush=0. ID advances and a nop enters ID.
  4. Otherwise: pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0.
- MDU state machine, with states RUN (mdu_cnt==0) and MDU_BUSY (mdu_cnt!=0):
  - issue = id_is_mdu & !id_stall & !ex_branch_taken.
  - On issue, mdu_cnt <= MDU_LATENCY. This reloads even when already busy; that case cannot arise, since id_is_mdu stalls while busy.
  - Else if mdu_cnt!=0, mdu_cnt decrements by 1.
  - A taken branch does not cancel an MDU op already in flight; the countdown continues.
  - mdu_busy = (mdu_cnt!=0), registered-state derived.
- Latency: a mfhi immediately following a mult stalls exactly MDU_LATENCY cycles.
- stall_cycles increments on each clock with id_stall & !ex_branch_taken. flush_count increments on each ex_branch_taken cycle. Both saturate at all-ones with no wrap.
- Reset asserted mid-stall or mid-MDU clears everything immediately. After release, the first edge behaves as RUN with an empty MDU.
- The $zero destination never causes a load-use stall.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8; ID uses rs=8 -> exactly 1 cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cycles 0->1. Repeat with ex_rt=0 -> no stall.
- Branch during stall: load-use active and ex_branch_taken=1 the same cycle -> pc_en=1, ifid_flush=1, idex_flush=1; stall_cycles unchanged; flush_count +1.
- MDU: mult issues, then mfhi in ID next cycle (MDU_LATENCY=4) -> mdu_busy high 4 cycles; mfhi stalls 4 cycles and advances on the 5th.
- Imem wait: imem_ready=0 for 3 cycles, no hazards -> pc_en=0, ifid_flush=1, ifid_en=1 for 3 cycles; then resume; stall_cycles unchanged.
- Reset mid-MDU: assert reset with mdu_cnt=2 -> mdu_busy=0 and counters=0 immediately (asynchronously); after release a following mfhi does not stall.
- Saturation: force 2^CNT_W+5 stall cycles (use CNT_W=4 in the bench) -> stall_cycles holds at 15.
